ysyx_24100013_ifu: RTL



---
 rtl/ysyx_24100013_pkg.sv | 19 +
 rtl/ysyx_24100013_ifu_buf.sv | 52 +++++
 rtl/ysyx_24100013_ifu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100013_pkg.sv
// Shared definitions for the ysyx_24100013 core front end.
//   ifu_state_e      : fetch unit FSM states (2 bits)
//   DEFAULT_RESET_PC : boot address
//   NOP_INST         : addi x0, x0, 0
//   EBREAK_INST      : ebreak encoding, used by the trap path
package ysyx_24100013_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

endpackage

// File: rtl/ysyx_24100013_ifu_buf.sv
// One-entry instruction holding buffer between fetch and decode.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   load, load_inst/pc/fault          capture a new entry (wins over clear)
//   clear                             drop the entry (consumed or flushed)
//   valid, inst, inst_pc, fault       held entry; payload is stable until the next load
module ysyx_24100013_ifu_buf
  import ysyx_24100013_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        load_fault,
  input  logic        clear,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      inst_q  <= load_inst;
      pc_q    <= load_pc;
      fault_q <= load_fault;
    end else if (clear) begin
      // Payload is left in place; only the valid bit drops.
      valid_q <= 1'b0;
    end
  end

  assign valid   = valid_q;
  assign inst    = inst_q;
  assign inst_pc = pc_q;
  assign fault   = fault_q;

endmodule

// File: rtl/ysyx_24100013_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time over a
// valid/ready request channel, buffers the response and hands it to decode.
// Ports:
//   clk, rst_n                                 clock, async active-low reset
//   halt                                       park in IDLE at the next decision point
//   redirect_valid, redirect_pc                PC redirect from execute (highest priority)
//   req_valid, req_ready, req_addr             fetch request channel
//   rsp_valid, rsp_data, rsp_err               fetch response channel (always accepted)
//   inst_valid, inst_ready, inst, inst_pc,
//   inst_fault                                 decode handshake
// Build option IFU_ALIGN_CHECK_EN: a misaligned redirect target is not fetched;
// a faulting nop is presented at that PC instead. Without it the low two
// target bits are cleared and the fetch proceeds normally.
module ysyx_24100013_ifu
  import ysyx_24100013_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic        drop_q;   // response of the outstanding request must be discarded

  logic        req_hs;
  logic        rsp_take;
  logic        buf_valid;
  logic        buf_load;
  logic        buf_clear;
  logic [31:0] redirect_target;
  logic [31:0] load_inst;
  logic [31:0] load_pc;
  logic        load_fault;

  assign req_valid = (state_q == StReq);
  assign req_addr  = pc_q;
  assign req_hs    = req_valid & req_ready;
  assign rsp_take  = (state_q == StWait) & rsp_valid;

  // A redirect kills the held instruction in the same cycle.
  assign inst_valid = buf_valid & ~redirect_valid;
  assign buf_clear  = (state_q == StHold) & (redirect_valid | inst_ready);

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_q;   // the redirect that set drop_q was misaligned
  logic redirect_mis;
  logic nop_direct;
  logic nop_drained;

  assign redirect_target = redirect_pc;
  assign redirect_mis    = redirect_valid & (redirect_pc[1:0] != 2'b00);
  // No request in flight (or its response lands now): present the nop at once.
  assign nop_direct  = redirect_mis & ((state_q == StIdle) | (state_q == StHold) |
                                       ((state_q == StReq) & ~req_hs) | rsp_take);
  // Pending request drained: the nop goes out at the redirect PC held in pc_q.
  assign nop_drained = rsp_take & drop_q & misalign_q & ~redirect_valid;

  assign buf_load   = (rsp_take & ~drop_q & ~redirect_valid) | nop_direct | nop_drained;
  assign load_inst  = (nop_direct | nop_drained) ? NOP_INST : rsp_data;
  assign load_pc    = nop_direct ? redirect_pc : pc_q;
  assign load_fault = (nop_direct | nop_drained) ? 1'b1 : rsp_err;
`else
  assign redirect_target = redirect_pc & ~32'h3;
  assign buf_load        = rsp_take & ~drop_q & ~redirect_valid;
  assign load_inst       = rsp_data;
  assign load_pc         = pc_q;
  assign load_fault      = rsp_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_target;
`ifdef IFU_ALIGN_CHECK_EN
        misalign_q <= redirect_mis;
`endif
      end
      unique case (state_q)
        StIdle: begin
          if (buf_load) begin
            state_q <= StHold;
          end else if (!redirect_valid && !halt) begin
            state_q <= StReq;
          end
        end
        StReq: begin
          if (req_hs) begin
            // Redirect racing the handshake: the old fetch is in flight, drain it.
            state_q <= StWait;
            drop_q  <= redirect_valid;
          end else if (buf_load) begin
            state_q <= StHold;
          end else if (!redirect_valid && halt) begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (rsp_valid) begin
            drop_q <= 1'b0;
            if (buf_load) begin
              state_q <= StHold;
            end else if (redirect_valid || !halt) begin
              state_q <= StReq;
            end else begin
              state_q <= StIdle;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        StHold: begin
          if (!buf_load) begin
            if (redirect_valid) begin
              state_q <= StReq;
            end else if (inst_ready) begin
              pc_q    <= pc_q + 32'(PC_STEP);
              state_q <= halt ? StIdle : StReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ysyx_24100013_ifu_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .load_inst  (load_inst),
    .load_pc    (load_pc),
    .load_fault (load_fault),
    .clear      (buf_clear),
    .valid      (buf_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .fault      (inst_fault)
  );

endmodule
